// File: rtl/sd_sector_arbiter_if.sv
// sd_sector_arbiter_if
//   Bundles every signal between the sector arbiter, the NREQ drive
//   models and the IO controller's block-level SD port.
//
//   Requester side : req_lba, req_rd, req_wr, req_buff_din  (to arbiter)
//                    req_ack, req_done, req_err, req_buff_wr (from arbiter)
//   IO block side  : sd_ack, sd_buff_wr                      (to arbiter)
//                    sd_lba, sd_rd, sd_wr, sd_buff_din       (from arbiter)
//   Status         : grant (current/last grantee), arb_state (FSM state)
//
//   Modport master is the arbiter; modport slave is the surrounding
//   logic (drive models plus IO block).
//
//   Handshake: a requester raises req_rd/req_wr as a level and holds it
//   until it sees its req_done pulse, then drops it in that same cycle.
//   The IO block answers sd_rd/sd_wr with sd_ack high for the length of
//   the transfer; sd_buff_wr strobes are only honoured while sd_ack is high.
interface sd_sector_arbiter_if #(
    parameter int NREQ = 2
);
    logic [32*NREQ-1:0] req_lba;
    logic [NREQ-1:0]    req_rd;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    req_done;
    logic [NREQ-1:0]    req_err;
    logic [NREQ-1:0]    req_buff_wr;
    logic [8*NREQ-1:0]  req_buff_din;
    logic [31:0]        sd_lba;
    logic               sd_rd;
    logic               sd_wr;
    logic               sd_ack;
    logic               sd_buff_wr;
    logic [7:0]         sd_buff_din;
    logic [1:0]         grant;
    logic [1:0]         arb_state;

    modport master (
        input  req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
        output req_ack, req_done, req_err, req_buff_wr,
               sd_lba, sd_rd, sd_wr, sd_buff_din, grant, arb_state
    );

    modport slave (
        output req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
        input  req_ack, req_done, req_err, req_buff_wr,
               sd_lba, sd_rd, sd_wr, sd_buff_din, grant, arb_state
    );
endinterface

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
//   Shares the single block-level SD port of the IO controller between
//   NREQ (2..4) drive requesters with a round-robin grant. The arbiter
//   runs the IDLE -> REQ -> XFER -> DONE sequence toward the IO block,
//   steers sd_buff_wr to the grantee and muxes the grantee's buffer data
//   onto sd_buff_din.
//
//   Ports:
//     clk_sys  - system clock, all logic on posedge
//     reset_n  - synchronous active-low reset
//     bus      - sd_sector_arbiter_if.master (requester + IO block signals,
//                grant and arb_state debug output)
//
//   Optional feature macro: SD_ARB_TIMEOUT_EN
//     defined   - REQ is abandoned after TIMEOUT cycles without sd_ack;
//                 req_done and req_err pulse together for the grantee.
//     undefined - REQ waits for sd_ack indefinitely, req_err is tied low.
module sd_sector_arbiter #(
    parameter int          NREQ    = 2,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input logic                 clk_sys,
    input logic                 reset_n,
    sd_sector_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [1:0]      grant_q;
    logic [1:0]      rr_q;
    logic [31:0]     sd_lba_q;
    logic            sd_rd_q;
    logic            sd_wr_q;
    logic [NREQ-1:0] req_done_q;

    logic [NREQ-1:0] pending;
    logic            found;
    logic [2:0]      idx;
    logic [1:0]      win;
    logic [31:0]     win_lba;
    logic            win_rd;
    logic            win_wr;
    logic [1:0]      rr_d;
    logic [NREQ-1:0] grant_oh;

    // Round-robin search starting at rr_q; idx wraps modulo NREQ, which
    // need not be a power of two.
    always_comb begin
        pending = bus.req_rd | bus.req_wr;
        found   = 1'b0;
        win     = rr_q;
        idx     = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!found && idx == 3'(i) && pending[i]) begin
                    found = 1'b1;
                    win   = 2'(i);
                end
            end
        end
        win_lba = 32'd0;
        win_rd  = 1'b0;
        win_wr  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 2'(i)) begin
                win_lba = bus.req_lba[32*i +: 32];
                win_rd  = bus.req_rd[i];
                win_wr  = bus.req_wr[i];
            end
        end
        rr_d = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;
    end

    // Grantee steering: acks and buffer strobes reach only the grantee and
    // only during XFER, so a stray sd_ack in IDLE reaches nobody.
    always_comb begin
        bus.sd_buff_din = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i]        = (grant_q == 2'(i));
            bus.req_ack[i]     = grant_oh[i] && (state_q == XFER) && bus.sd_ack;
            bus.req_buff_wr[i] = grant_oh[i] && (state_q == XFER) && bus.sd_buff_wr;
            if (grant_oh[i]) bus.sd_buff_din = bus.req_buff_din[8*i +: 8];
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0]     to_cnt_q;
    logic [NREQ-1:0] req_err_q;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= 2'd0;
            rr_q       <= 2'd0;
            sd_lba_q   <= 32'd0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            req_done_q <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            to_cnt_q   <= 24'd0;
            req_err_q  <= '0;
`endif
        end else begin
            req_done_q <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            req_err_q  <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (found) begin
                        sd_lba_q <= win_lba;
                        grant_q  <= win;
                        // Read wins when both are set; the write stays pending.
                        sd_rd_q  <= win_rd;
                        sd_wr_q  <= win_wr & ~win_rd;
                        state_q  <= REQ;
`ifdef SD_ARB_TIMEOUT_EN
                        to_cnt_q <= 24'd0;
`endif
                    end
                end
                REQ: begin
                    if (bus.sd_ack) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= XFER;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (to_cnt_q == TIMEOUT - 24'd1) begin
                        sd_rd_q    <= 1'b0;
                        sd_wr_q    <= 1'b0;
                        req_done_q <= grant_oh;
                        req_err_q  <= grant_oh;
                        state_q    <= DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 24'd1;
                    end
`endif
                end
                XFER: begin
                    if (!bus.sd_ack) begin
                        req_done_q <= grant_oh;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    rr_q    <= rr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sd_lba    = sd_lba_q;
    assign bus.sd_rd     = sd_rd_q;
    assign bus.sd_wr     = sd_wr_q;
    assign bus.req_done  = req_done_q;
    assign bus.grant     = grant_q;
    assign bus.arb_state = state_q;

`ifdef SD_ARB_TIMEOUT_EN
    assign bus.req_err = req_err_q;
`else
    assign bus.req_err = '0;
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif
endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares the single block-level SD interface of the MiST IO controller (sd_lba/sd_rd/sd_wr/sd_ack plus the 512-byte sd_buff port) between NREQ disk-drive requesters, e.g. FDC drive A/B or a hard-disk emulator.
- Round-robin grant; the arbiter owns the transaction sequence to the ARM-side IO controller.
- Steers buffer write strobes and read-back data to and from the granted requester only.
- Sits in clk_sys, directly between the drive models and the IO block.

Parameters:
- NREQ, 2: number of requesters (2..4).
- TIMEOUT, 24'd10_000_000: clk_sys cycles allowed in REQ without sd_ack (only used with SD_ARB_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock; all logic on its posedge.
- reset_n  in  1  synchronous, active-low reset.
- req_lba  in  32*NREQ  per-requester sector LBA; requester i uses [32*i +: 32].
- req_rd  in  NREQ  level read request.
- req_wr  in  NREQ  level write request.
- req_ack  out  NREQ  high while requester i's transfer is in progress (sd_ack mirrored to the grantee).
- req_done  out  NREQ  1-cycle pulse when requester i's transaction ends.
- req_err  out  NREQ  1-cycle pulse together with req_done on timeout.
- req_buff_wr  out  NREQ  sd_buff_wr gated to the grantee.
- req_buff_din  in  8*NREQ  per-requester buffer read data for writes to SD.
- sd_lba  out  32  to IO block.
- sd_rd  out  1  to IO block.
- sd_wr  out  1  to IO block.
- sd_ack  in  1  from IO block; already in the clk_sys domain.
- sd_buff_wr  in  1  from IO block.
- sd_buff_din  out  8  to IO block; muxed from req_buff_din of the grantee.
- grant  out  2  index of the current or last grantee.

Sd_buff_addr and sd_buff_dout are broadcast to all requesters outside this block.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge), all registered:
  - sd_rd=0, sd_wr=0, sd_lba=0.
  - req_ack=0, req_done=0, req_err=0.
  - grant=0, round-robin pointer rr=0, state=IDLE, timeout counter=0.
  - Reset mid-transfer drops sd_rd/sd_wr immediately. No req_done is issued.
- States: IDLE -> REQ -> XFER -> DONE -> IDLE.
- IDLE:
  - Pending requester i is one with req_rd[i]|req_wr[i].
  - Search starts at rr and wraps modulo NREQ; the first pending index wins.
  - On a win: latch sd_lba<=req_lba[i] and grant<=i.
  - sd_rd<=req_rd[i]; sd_wr<=req_wr[i]&~req_rd[i], so read wins if both are set; the write stays pending.
  - Next state REQ, with sd_rd/sd_wr visible the cycle after the request is seen (latency 1).
- REQ:
  - Hold sd_rd/sd_wr and sd_lba.
  - When sd_ack=1: deassert sd_rd/sd_wr and go to XFER.
- XFER:
  - req_ack[grant]=1 combinationally from sd_ack; other req_ack bits are 0.
  - req_buff_wr[grant]=sd_buff_wr; other req_buff_wr bits are 0.
  - When sd_ack=0: go to DONE.
- DONE (exactly one cycle):
  - req_done[grant]=1.
  - rr<=(grant+1) mod NREQ.
  - Next state IDLE.
  - The requester must drop its request on the req_done cycle. A request still held in IDLE is treated as a new transaction.
- Muxing:
  - sd_buff_din=req_buff_din[grant] at all times (combinational mux). grant stays stable from IDLE-win until the next win.
  - sd_lba is held from latch until the next grant. Requester LBA changes during REQ/XFER are ignored.
- Request dropped during REQ: the arbiter continues the transaction; completion is still signalled.
- sd_ack=1 in IDLE (stray ack): ignored. No req_ack bit asserted.
- Any cycle has at most one req_done bit and at most one req_ack bit set.

Optional Feature:
- Macro SD_ARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT-1 without sd_ack: deassert sd_rd/sd_wr, go to DONE, pulse req_done[grant] and req_err[grant] together.
  - rr advances as normal.
- Undefined:
  - No counter; REQ waits indefinitely.
  - req_err is tied to 0.

Test Plan:
- Single read: NREQ=2, req_rd[1]=1, req_lba[63:32]=0x00000123 -> next cycle sd_rd=1, sd_lba=0x123, grant=1. Model sd_ack high 520 cycles with 512 sd_buff_wr pulses -> req_buff_wr[1] gets 512 pulses, req_buff_wr[0] none, req_ack[1] mirrors sd_ack, one req_done[1] pulse after ack falls.
- Contention: req_rd[0] and req_wr[1] set in the same cycle with rr=0 -> requester 0 served first, then requester 1 with sd_wr=1; third round with both still pending -> requester 0 again.
- Write data steering: grant=1, req_buff_din[15:8]=0xA5, req_buff_din[7:0]=0x3C -> sd_buff_din=0xA5 throughout XFER.
- Both rd and wr on requester 0 -> sd_rd=1, sd_wr=0. After req_done, with req_rd dropped and req_wr held -> second transaction with sd_wr=1.
- Reset mid-XFER: reset_n=0 for one cycle while sd_ack=1 -> sd_rd=sd_wr=0, req_ack=0, no req_done, grant=0, state IDLE.
- Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT=16): req_rd[0]=1 with no sd_ack -> sd_rd drops after 16 REQ cycles; req_done[0] and req_err[0] pulse together, and requester 1 is searched first next.
